// File: rtl/buffer_arb.sv
// Single-entry registered stage shared by four requesters under round-robin arbitration.
// One-cycle req-to-out latency; reloads in the consume edge for full throughput, holds while out_ready=0.
module buffer_arb #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       en,
  input  logic [3:0]       req,
  input  logic [width-1:0] data0,
  input  logic [width-1:0] data1,
  input  logic [width-1:0] data2,
  input  logic [width-1:0] data3,
  output logic [3:0]       gnt,
  output logic [width-1:0] out,
  output logic [1:0]       out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic [3:0]       elig;
  logic [width-1:0] win_data;

  assign load = (state == EMPTY) || out_ready;
  assign elig = req & en;

  // Search upward from the slot after the previous winner; the 2-bit add wraps mod 4.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (!rst || !load) found = 1'b0;
    gnt = found ? (4'b0001 << win) : 4'b0000;
  end

  always_comb begin
    case (win)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out       <= '0;
      out_src   <= 2'd0;
      last      <= 2'd3;
    end else if (found) begin
      state     <= FULL;
      out_valid <= 1'b1;
      out       <= win_data;
      out_src   <= win;
      last      <= win;
    end else if (state == FULL && out_ready) begin
      // Drained with nothing to reload: payload is left in place.
      state     <= EMPTY;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buffer_arb.sv
// Scoreboarded bench for buffer_arb: randomized requesters against a round-robin reference model.
module tb_buffer_arb;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] dat;
    logic [1:0]   src;
  } word_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   en = 4'b0;
  logic [3:0]   req = 4'b0;
  logic [W-1:0] d [4];
  logic [3:0]   gnt;
  logic [W-1:0] out;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready = 1'b0;

  buffer_arb #(.width(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
    .gnt(gnt), .out(out), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  word_t        q[$];
  int           checks = 0;
  int           fails = 0;
  bit           m_full = 1'b0;
  int           m_last = 3;
  bit           exp_valid = 1'b0;
  int           last_w = -1;
  logic [W-1:0] nd [4];
  logic [W-1:0] last_out = '0;
  logic [1:0]   last_src = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, then predict grant and next state from the arbitration rules.
  task automatic tick(input logic r, input logic [3:0] e, input logic [3:0] rq, input logic rdy);
    logic [3:0] eg;
    int w;
    @(negedge clk);
    rst = r; en = e; req = rq; out_ready = rdy;
    for (int i = 0; i < 4; i++) d[i] = nd[i];
    #1;
    exp_valid = m_full;
    w = -1;
    if (r && (!m_full || rdy))
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_last + k) % 4;
        if (w < 0 && rq[i] && e[i]) w = i;
      end
    eg = 4'b0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", {28'b0, gnt}, {28'b0, eg});
    if (!r) begin
      q.delete();
      m_full = 1'b0;
      m_last = 3;
    end else if (w >= 0) begin
      q.push_back('{dat: d[w], src: 2'(w)});
      m_full = 1'b1;
      m_last = w;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    last_w = w;
  endtask

  // Monitor: compares what the DUT presents against the scoreboard, popping on each consume.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        last_out = '0;
        last_src = 2'd0;
      end else begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_empty at %0t: out_valid=1 with no expected word", $time);
          end else begin
            chk("out", {16'b0, out}, {16'b0, q[0].dat});
            chk("out_src", {30'b0, out_src}, {30'b0, q[0].src});
            if (out_ready) begin
              last_out = q[0].dat;
              last_src = q[0].src;
              void'(q.pop_front());
            end
          end
        end else begin
          chk("out_retained", {16'b0, out}, {16'b0, last_out});
          chk("src_retained", {30'b0, out_src}, {30'b0, last_src});
        end
      end
    end
  end

  initial begin
    logic [3:0] rv;
    logic [3:0] ev;
    logic       rs;
    for (int i = 0; i < 4; i++) begin
      nd[i] = W'($urandom);
      d[i] = nd[i];
    end

    // Reset state
    tick(1'b0, 4'b1111, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", {16'b0, out}, 32'd0);
    chk("rst_out_src", {30'b0, out_src}, 32'd0);

    // All requesting: rotation 0,1,2,3,...
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b1111, 4'b1111, 1'b1);
    tick(1'b1, 4'b1111, 4'b0000, 1'b1);

    // Stall with a single word from requester 2
    nd[2] = 16'hA5A5;
    tick(1'b1, 4'b1111, 4'b0100, 1'b0);
    for (int c = 0; c < 5; c++) tick(1'b1, 4'b1111, 4'b0100, 1'b0);
    chk("stall_out", {16'b0, out}, 32'h0000A5A5);
    tick(1'b1, 4'b1111, 4'b0100, 1'b1);
    tick(1'b1, 4'b1111, 4'b0000, 1'b1);
    tick(1'b1, 4'b1111, 4'b0000, 1'b1);

    // Enable mask excludes 0 and 2
    for (int c = 0; c < 6; c++) tick(1'b1, 4'b1010, 4'b1111, 1'b1);

    // Wrap-around after last=1
    tick(1'b1, 4'b1111, 4'b0010, 1'b1);
    tick(1'b1, 4'b1111, 4'b0011, 1'b1);
    tick(1'b1, 4'b1111, 4'b0011, 1'b1);

    // Drain to EMPTY, then refill and reset while FULL
    tick(1'b1, 4'b1111, 4'b0000, 1'b1);
    tick(1'b1, 4'b1111, 4'b1000, 1'b0);
    tick(1'b0, 4'b1111, 4'b1000, 1'b0);
    tick(1'b1, 4'b1111, 4'b1010, 1'b1);
    tick(1'b1, 4'b1111, 4'b0000, 1'b1);

    // Randomized traffic; requesters hold req/data until granted
    rv = 4'b0;
    ev = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          nd[i] = W'($urandom);
        end
      if ($urandom_range(0, 15) == 0) ev = 4'($urandom);
      rs = ($urandom_range(0, 49) != 0);
      tick(rs, ev, rv, 1'($urandom_range(0, 3) != 0));
      if (last_w >= 0) rv[last_w] = 1'b0;
    end

    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/buffer_arb.md
BUFFER_ARB -- requirements
Module: buffer_arb

Interface
REQ-001 Parameter: width, default 16, data width of every requester port and of out.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 en  input  4  per-requester enable mask; en[i]=0 excludes requester i from arbitration.
REQ-005 req  input  4  request; req[i]=1 means requester i offers data_i.
REQ-006 data0..data3  input  width each  requester payloads.
REQ-007 gnt  output  4  one-hot (or zero) combinational grant; a transfer from i occurs on an edge where req[i]=1 and gnt[i]=1.
REQ-008 out  output  width  registered payload.
REQ-009 out_src  output  2  index of requester that supplied out.
REQ-010 out_valid  output  1  out/out_src hold a valid word.
REQ-011 out_ready  input  1  downstream accepts; a word is consumed on an edge where out_valid=1 and out_ready=1.

Function
REQ-012 Block SHALL be a single-entry registered stage shared by four requesters under round-robin arbitration.
REQ-013 State machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 load = EMPTY, or FULL with out_ready=1.
REQ-015 Eligible set SHALL be req & en; gnt SHALL be zero when load=0 or the eligible set is empty.
REQ-016 When load=1 and the eligible set is non-empty, gnt SHALL select the first eligible index searching upward modulo 4 from last+1, where last is the 2-bit index of the most recent winner.
REQ-017 On a grant edge: out<=data_w, out_src<=w, out_valid<=1, last<=w; latency from req to out_valid SHALL be one cycle.
REQ-018 FULL with out_ready=1 and a grant SHALL reload in the same edge (back-to-back, no bubble, 100% throughput).
REQ-019 FULL with out_ready=1 and no grant SHALL go to EMPTY; out and out_src SHALL retain their value.
REQ-020 FULL with out_ready=0 SHALL hold out, out_src, out_valid, last unchanged; gnt=0.
REQ-021 EMPTY with no eligible request SHALL remain EMPTY; last unchanged.
REQ-022 last SHALL change only on a grant edge.
REQ-023 Dropping en[i] while req[i] is pending SHALL only exclude i from future grants; a word already in out is unaffected.
REQ-024 A single continuously requesting requester SHALL be granted every load cycle; with k eligible continuous requesters each SHALL be granted once every k transfers.
REQ-025 gnt SHALL depend on rst: gnt=0 whenever rst=0.
REQ-026 Requesters SHALL hold req and data stable until granted; block does not buffer ungranted data.

Reset
REQ-027 On a rising edge with rst=0: out_valid<=0, out<=0, out_src<=0, last<=3 (requester 0 has highest priority first), state EMPTY.
REQ-028 Reset SHALL override any concurrent transfer or consume; a word in FULL is discarded.
REQ-029 After rst returns to 1, first grant SHALL be possible on the first edge.

Verification
REQ-030 Reset then req=4'b1111, en=4'b1111, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, out_valid=1 from first edge after grant, gnt one-hot every cycle.
REQ-031 data2=16'hA5A5, req=4'b0100, out_ready=0 -> out=A5A5, out_src=2 after one edge; out, out_valid held and gnt=0 for 5 stalled cycles; out_ready=1 -> word consumed, next grant same edge.
REQ-032 en=4'b1010, req=4'b1111, out_ready=1 -> out_src alternates 1,3,1,3; gnt[0], gnt[2] never asserted.
REQ-033 After last=1, req=4'b0011 -> next grant is 0, then 1 (wrap-around of round-robin search).
REQ-034 FULL, out_ready=1, req=0 -> out_valid falls to 0 next edge, out retains value; rst=0 while FULL -> out_valid=0, out=0, out_src=0, following grant to lowest eligible index from 0.
